// File: rtl/clock_ctrl_pkg.sv
// Shared constants and state encoding for the lab clock-rate controller.
package clock_ctrl_pkg;

  localparam int RATE_MIN = 4;
  localparam int RATE_MAX = 24;
  localparam int RATE_W   = 5;
  localparam int CNT_W    = 25;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STEP = 1'b1
  } state_t;

  // Low (rate+1) bits set; rate 24 wraps the shift to zero and yields all ones.
  function automatic logic [CNT_W-1:0] rate_mask(input logic [RATE_W-1:0] rate);
    return (CNT_W'(1) << (rate + RATE_W'(1))) - CNT_W'(1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One board key: 2-flop synchronizer, polarity fix, stability counter and
// a single-cycle press strobe on each accepted release-to-press change.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic osc_50,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           IDLE = KEY_ACTIVE_LOW;

  logic          sync_p0, sync_p1;
  logic          key_now;
  logic          level_d;
  logic [CW-1:0] count;

  // Synchronizer resets to the released level so a held key re-presses.
  always_ff @(posedge osc_50) begin
    if (reset) begin
      sync_p0 <= IDLE;
      sync_p1 <= IDLE;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign key_now = KEY_ACTIVE_LOW ? ~sync_p1 : sync_p1;

  always_ff @(posedge osc_50) begin
    if (reset) begin
      level <= 1'b0;
      count <= '0;
    end else if (key_now != level) begin
      if (count == LAST) begin
        level <= key_now;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end else begin
      count <= '0;
    end
  end

  always_ff @(posedge osc_50) begin
    if (reset) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/clock_rate_controller.sv
// Run/step clock-enable generator: debounced keys select a divider exponent
// or switch to single-step mode where each step key press emits one tick.
module clock_rate_controller
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RESET_RATE      = 19,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic              osc_50,
  input  logic              reset,
  input  logic              key_faster,
  input  logic              key_slower,
  input  logic              key_mode,
  input  logic              key_step,
  output logic              tick,
  output logic [RATE_W-1:0] rate_sel,
  output logic              step_mode
);

  function automatic logic [RATE_W-1:0] rate_step(input logic [RATE_W-1:0] rate,
                                                  input logic dn, input logic up);
    if (dn && !up && rate > RATE_W'(RATE_MIN)) return rate - RATE_W'(1);
    if (up && !dn && rate < RATE_W'(RATE_MAX)) return rate + RATE_W'(1);
    return rate;
  endfunction

  logic [3:0]       keys;
  logic [3:0]       press;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] mask;
  logic             hit;
  logic             tick_next;
  state_t           state, state_next;

  assign keys = {key_step, key_mode, key_slower, key_faster};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_key (
      .osc_50 (osc_50),
      .reset  (reset),
      .key_raw(keys[i]),
      .level  (),
      .press  (press[i])
    );
  end

  always_ff @(posedge osc_50) begin
    if (reset) rate_sel <= RATE_W'(RESET_RATE);
    else       rate_sel <= rate_step(rate_sel, press[0], press[1]);
  end

  // Counter is never realigned on rate or mode changes, so no double pulse.
  always_ff @(posedge osc_50) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + CNT_W'(1);
  end

  assign mask = rate_mask(rate_sel);
  assign hit  = (cnt & mask) == mask;

  always_ff @(posedge osc_50) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (press[2]) begin
      case (state)
        ST_RUN:  state_next = ST_STEP;
        default: state_next = ST_RUN;
      endcase
    end
  end

  always_comb begin
    tick_next = 1'b0;
    case (state)
      ST_RUN:  tick_next = hit;
      default: tick_next = press[3];
    endcase
  end

  always_ff @(posedge osc_50) begin
    if (reset) tick <= 1'b0;
    else       tick <= tick_next;
  end

  assign step_mode = (state == ST_STEP);

endmodule
